// File: rtl/register_file_dp.sv
// Dual-read-port general register file with a single write/modify channel.
// Both read ports are registered and forward the post-modify value when they hit the target.
module register_file_dp #(
   parameter int unsigned WIDTH    = 16,
   parameter int unsigned DEPTH    = 32,
   parameter int unsigned ADDR_W   = 5,
   parameter int unsigned ZERO_REG = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [WIDTH-1:0]  din,
   input  logic [ADDR_W-1:0] id,
   input  logic              write,
   input  logic              writeu,
   input  logic              writel,
   input  logic              inc,
   input  logic              dec,
   input  logic              read_a,
   input  logic [ADDR_W-1:0] id_a,
   output logic [WIDTH-1:0]  dout_a,
   input  logic              read_b,
   input  logic [ADDR_W-1:0] id_b,
   output logic [WIDTH-1:0]  dout_b,
   output logic              wrap
);

   localparam int unsigned HALF = WIDTH / 2;

   logic [WIDTH-1:0] r_regs [DEPTH];
   logic [WIDTH-1:0] r_dout_a;
   logic [WIDTH-1:0] r_dout_b;
   logic             r_wrap;

   logic             w_mod;
   logic             w_wrap;
   logic [WIDTH-1:0] w_cur;
   logic [WIDTH-1:0] w_new;
   logic [WIDTH-1:0] w_rd_a;
   logic [WIDTH-1:0] w_rd_b;

   // A register id is usable when it is in range and not the hardwired zero register.
   function automatic logic f_valid(input logic [ADDR_W-1:0] x);
      return (32'(x) < DEPTH) && !((ZERO_REG != 0) && (x == '0));
   endfunction

   always_comb begin
      w_cur  = '0;
      w_new  = '0;
      w_wrap = 1'b0;
      w_mod  = f_valid(id) && (write || writeu || writel || inc || dec);
      if (f_valid(id)) begin
         w_cur = r_regs[id];
      end
      if (write) begin
         w_new = din;
      end else if (writeu) begin
         w_new = {din[HALF-1:0], w_cur[HALF-1:0]};
      end else if (writel) begin
         w_new = {w_cur[WIDTH-1:HALF], din[HALF-1:0]};
      end else if (inc) begin
         w_new  = w_cur + 1'b1;
         w_wrap = (w_cur == '1);
      end else if (dec) begin
         w_new  = w_cur - 1'b1;
         w_wrap = (w_cur == '0);
      end
   end

   always_comb begin
      w_rd_a = '0;
      if (f_valid(id_a)) begin
         w_rd_a = (w_mod && (id_a == id)) ? w_new : r_regs[id_a];
      end
   end

   always_comb begin
      w_rd_b = '0;
      if (f_valid(id_b)) begin
         w_rd_b = (w_mod && (id_b == id)) ? w_new : r_regs[id_b];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            r_regs[i] <= '0;
         end
         r_dout_a <= '0;
         r_dout_b <= '0;
         r_wrap   <= 1'b0;
      end else begin
         if (w_mod) begin
            r_regs[id] <= w_new;
         end
         if (read_a) begin
            r_dout_a <= w_rd_a;
         end
         if (read_b) begin
            r_dout_b <= w_rd_b;
         end
         r_wrap <= w_mod && w_wrap;
      end
   end

   assign dout_a = r_dout_a;
   assign dout_b = r_dout_b;
   assign wrap   = r_wrap;

endmodule

// File: tb/tb_register_file_dp.sv
// Directed bench for register_file_dp: default, zero-register and shallow instances share stimulus.
module tb_register_file_dp;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] din;
   logic [4:0]  id, id_a, id_b;
   logic        write, writeu, writel, inc, dec, read_a, read_b;

   logic [15:0] dout_a, dout_b, z_dout_a, z_dout_b, d_dout_a, d_dout_b;
   logic        wrap, z_wrap, d_wrap;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   register_file_dp u_dut (
      .clk(clk), .rst(rst), .din(din), .id(id), .write(write), .writeu(writeu),
      .writel(writel), .inc(inc), .dec(dec), .read_a(read_a), .id_a(id_a), .dout_a(dout_a),
      .read_b(read_b), .id_b(id_b), .dout_b(dout_b), .wrap(wrap)
   );

   register_file_dp #(.ZERO_REG(1)) u_dut_z (
      .clk(clk), .rst(rst), .din(din), .id(id), .write(write), .writeu(writeu),
      .writel(writel), .inc(inc), .dec(dec), .read_a(read_a), .id_a(id_a), .dout_a(z_dout_a),
      .read_b(read_b), .id_b(id_b), .dout_b(z_dout_b), .wrap(z_wrap)
   );

   register_file_dp #(.DEPTH(20)) u_dut_d (
      .clk(clk), .rst(rst), .din(din), .id(id), .write(write), .writeu(writeu),
      .writel(writel), .inc(inc), .dec(dec), .read_a(read_a), .id_a(id_a), .dout_a(d_dout_a),
      .read_b(read_b), .id_b(id_b), .dout_b(d_dout_b), .wrap(d_wrap)
   );

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic idle();
      rst = 1'b0; write = 1'b0; writeu = 1'b0; writel = 1'b0; inc = 1'b0; dec = 1'b0;
      read_a = 1'b0; read_b = 1'b0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      idle();
   endtask

   initial begin
      idle();
      din = '0; id = '0; id_a = '0; id_b = '0;

      // Reset
      rst = 1'b1; step();
      chk("rst_dout_a", dout_a, 16'h0000);
      chk("rst_wrap", {15'd0, wrap}, 16'h0000);
      read_a = 1'b1; id_a = 5'd3; read_b = 1'b1; id_b = 5'd31; step();
      chk("rd3_a", dout_a, 16'h0000);
      chk("rd31_b", dout_b, 16'h0000);
      chk("rd_wrap", {15'd0, wrap}, 16'h0000);

      // Half-word writes
      write = 1'b1; id = 5'd1; din = 16'h0F0F; step();
      writeu = 1'b1; id = 5'd1; din = 16'h00F3; read_b = 1'b1; id_b = 5'd1; step();
      chk("writeu_bypass_b", dout_b, 16'hF30F);
      writel = 1'b1; id = 5'd1; din = 16'h0012; step();
      read_a = 1'b1; id_a = 5'd1; step();
      chk("half_merge", dout_a, 16'hF312);
      writeu = 1'b1; writel = 1'b1; id = 5'd6; din = 16'h00AB; step();
      read_a = 1'b1; id_a = 5'd6; step();
      chk("writeu_over_writel", dout_a, 16'hAB00);

      // inc/dec wrap
      write = 1'b1; id = 5'd2; din = 16'hFFFF; step();
      chk("no_wrap_on_write", {15'd0, wrap}, 16'h0000);
      inc = 1'b1; id = 5'd2; read_a = 1'b1; id_a = 5'd2; step();
      chk("inc_wrap", {15'd0, wrap}, 16'h0001);
      chk("inc_val", dout_a, 16'h0000);
      dec = 1'b1; id = 5'd2; read_a = 1'b1; id_a = 5'd2; step();
      chk("dec_wrap", {15'd0, wrap}, 16'h0001);
      chk("dec_val", dout_a, 16'hFFFF);
      dec = 1'b1; id = 5'd2; read_a = 1'b1; id_a = 5'd2; step();
      chk("dec_nowrap", {15'd0, wrap}, 16'h0000);
      chk("dec_val2", dout_a, 16'hFFFE);

      // Write-first bypass on both ports
      write = 1'b1; id = 5'd5; din = 16'hABCD;
      read_a = 1'b1; id_a = 5'd5; read_b = 1'b1; id_b = 5'd5; step();
      chk("bypass_a", dout_a, 16'hABCD);
      chk("bypass_b", dout_b, 16'hABCD);
      inc = 1'b1; id = 5'd5; read_a = 1'b1; id_a = 5'd5; step();
      chk("inc_bypass_a", dout_a, 16'hABCE);
      chk("hold_b", dout_b, 16'hABCD);

      // Priority, then reset overriding a write
      write = 1'b1; inc = 1'b1; id = 5'd4; din = 16'h1234; read_a = 1'b1; id_a = 5'd4; step();
      chk("write_wins", dout_a, 16'h1234);
      chk("write_wins_wrap", {15'd0, wrap}, 16'h0000);
      rst = 1'b1; write = 1'b1; id = 5'd4; din = 16'h5555; step();
      chk("rst_ovr_a", dout_a, 16'h0000);
      chk("rst_ovr_b", dout_b, 16'h0000);
      read_a = 1'b1; id_a = 5'd4; read_b = 1'b1; id_b = 5'd1; step();
      chk("rst_r4", dout_a, 16'h0000);
      chk("rst_r1", dout_b, 16'h0000);

      // Zero register
      write = 1'b1; id = 5'd0; din = 16'hBEEF; step();
      read_a = 1'b1; id_a = 5'd0; step();
      chk("zero_r0", z_dout_a, 16'h0000);
      chk("plain_r0", dout_a, 16'hBEEF);
      dec = 1'b1; id = 5'd0; read_b = 1'b1; id_b = 5'd0; step();
      chk("zero_dec_wrap", {15'd0, z_wrap}, 16'h0000);
      chk("zero_bypass", z_dout_b, 16'h0000);

      // Out-of-range id on the 20-deep instance
      write = 1'b1; id = 5'd25; din = 16'h1111; step();
      read_a = 1'b1; id_a = 5'd25; step();
      chk("oor_read", d_dout_a, 16'h0000);
      chk("inrange_read", dout_a, 16'h1111);
      write = 1'b1; id = 5'd19; din = 16'h0000; step();
      dec = 1'b1; id = 5'd25; step();
      chk("oor_dec_wrap", {15'd0, d_wrap}, 16'h0000);
      dec = 1'b1; id = 5'd19; read_a = 1'b1; id_a = 5'd19; step();
      chk("last_reg_wrap", {15'd0, d_wrap}, 16'h0001);
      chk("last_reg_val", d_dout_a, 16'hFFFF);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
